// File: rtl/fifo_cmd_reader_if.sv
// Bundle between the command FIFO read port, the command reader and the rasterizer
// front end.
//   master modport (the reader):
//     in : empty, r_data, cmd_ready, flush
//     out: r_enable, cmd_valid, cmd_opcode, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
//          err, cmd_count
//   slave modport (FIFO / downstream / control side): the same signals, reversed.
interface fifo_cmd_reader_if #(
    parameter int unsigned DATA_W = 83,
    parameter int unsigned CNT_W  = 16
);
    logic              empty;
    logic [DATA_W-1:0] r_data;
    logic              r_enable;
    logic              cmd_ready;
    logic              cmd_valid;
    logic [2:0]        cmd_opcode;
    logic [9:0]        cmd_x0;
    logic [8:0]        cmd_y0;
    logic [9:0]        cmd_x1;
    logic [8:0]        cmd_y1;
    logic [23:0]       cmd_color;
    logic              flush;
    logic              err;
    logic [CNT_W-1:0]  cmd_count;

    modport master (
        input  empty, r_data, cmd_ready, flush,
        output r_enable, cmd_valid, cmd_opcode, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
               err, cmd_count
    );

    modport slave (
        output empty, r_data, cmd_ready, flush,
        input  r_enable, cmd_valid, cmd_opcode, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
               err, cmd_count
    );
endinterface

// File: rtl/fifo_cmd_reader.sv
// Read-side consumer of the 4-entry GPU command FIFO. Pops first-word-fall-through
// words, unpacks them into draw-command fields and offers them downstream over a
// valid/ready handshake. NOP words are dropped, an ILLEGAL opcode traps until a
// flush, and a flush drains the FIFO.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fifo_cmd_reader_if.master (FIFO read port, command outputs, flush, err,
//          issued-command counter)
module fifo_cmd_reader #(
    parameter int unsigned DATA_W = 83,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    fifo_cmd_reader_if.master bus
);
    localparam logic [2:0] OpNop     = 3'b111;
    localparam logic [2:0] OpIllegal = 3'b110;

    typedef enum logic [1:0] {StRun, StFlush, StError} state_e;

    state_e           state_q;
    logic             valid_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       opcode_q;
    logic [9:0]       x0_q;
    logic [8:0]       y0_q;
    logic [9:0]       x1_q;
    logic [8:0]       y1_q;
    logic [23:0]      color_q;

    logic [DATA_W-1:0] word;
    logic [2:0]        word_op;
    logic              pop;
    logic              handshake;
    logic              unused_rsvd;

    assign word        = bus.r_data;
    assign word_op     = word[82:80];
    assign unused_rsvd = ^word[17:0];
    assign handshake   = valid_q && bus.cmd_ready;

    // Pop strobe is combinational so a new word can be taken on the same edge the
    // current command handshakes.
    always_comb begin
        pop = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun:   pop = !bus.empty && (!valid_q || bus.cmd_ready) && !bus.flush;
                StFlush: pop = !bus.empty;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            opcode_q <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
        end else if (bus.flush) begin
            // A command pending on this edge is dropped and not counted.
            state_q <= StFlush;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (handshake) begin
                count_q <= count_q + 1'b1;
                valid_q <= 1'b0;
            end
            case (state_q)
                StRun: begin
                    if (pop) begin
                        if (word_op == OpIllegal) begin
                            err_q   <= 1'b1;
                            state_q <= StError;
                        end else if (word_op != OpNop) begin
                            // Overrides the handshake clear above: back-to-back issue.
                            valid_q  <= 1'b1;
                            opcode_q <= word[82:80];
                            x0_q     <= word[79:70];
                            y0_q     <= word[69:61];
                            x1_q     <= word[60:51];
                            y1_q     <= word[50:42];
                            color_q  <= word[41:18];
                        end
                    end
                end
                StFlush: begin
                    if (bus.empty) begin
                        state_q <= StRun;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.r_enable   = pop;
    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_opcode = opcode_q;
    assign bus.cmd_x0     = x0_q;
    assign bus.cmd_y0     = y0_q;
    assign bus.cmd_x1     = x1_q;
    assign bus.cmd_y1     = y1_q;
    assign bus.cmd_color  = color_q;
    assign bus.err        = err_q;
    assign bus.cmd_count  = count_q;
endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Directed bench for fifo_cmd_reader: a queue stands in for the FIFO, a behavioural
// model predicts every output each cycle, and literal checks pin the key values.
module tb_fifo_cmd_reader;
    logic clk;
    logic rst;

    fifo_cmd_reader_if #(.DATA_W(83), .CNT_W(16)) bus ();

    fifo_cmd_reader #(.DATA_W(83), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [82:0] fifo[$];

    // Model state: mode 0 = accepting, 1 = draining, 2 = trapped.
    int          m_mode;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_count;
    logic [82:0] m_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.empty  = (fifo.size() == 0);
        bus.r_data = (fifo.size() == 0) ? 83'd0 : fifo[0];
    endtask

    function automatic logic [82:0] mk(input logic [2:0] op, input logic [9:0] x0,
                                       input logic [8:0] y0, input logic [9:0] x1,
                                       input logic [8:0] y1, input logic [23:0] c);
        return {op, x0, y0, x1, y1, c, 18'h2_5A5A};
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge.
    task automatic check_cycle();
        logic exp_pop;
        logic [2:0] op;
        if (rst) begin
            m_mode = 0; m_valid = 0; m_err = 0; m_count = 0; m_word = '0;
        end
        if (rst)              exp_pop = 0;
        else if (m_mode == 1) exp_pop = !bus.empty;
        else if (m_mode == 2) exp_pop = 0;
        else exp_pop = !bus.empty && !bus.flush && (!m_valid || bus.cmd_ready);

        chk("r_enable",   64'(bus.r_enable),  64'(exp_pop));
        chk("cmd_valid",  64'(bus.cmd_valid), 64'(m_valid));
        chk("err",        64'(bus.err),       64'(m_err));
        chk("cmd_count",  64'(bus.cmd_count), 64'(m_count));
        chk("cmd_opcode", 64'(bus.cmd_opcode), 64'(m_word[82:80]));
        chk("cmd_x0",     64'(bus.cmd_x0),    64'(m_word[79:70]));
        chk("cmd_y0",     64'(bus.cmd_y0),    64'(m_word[69:61]));
        chk("cmd_x1",     64'(bus.cmd_x1),    64'(m_word[60:51]));
        chk("cmd_y1",     64'(bus.cmd_y1),    64'(m_word[50:42]));
        chk("cmd_color",  64'(bus.cmd_color), 64'(m_word[41:18]));

        if (!rst) begin
            if (bus.flush) begin
                m_mode = 1; m_valid = 0; m_err = 0;
            end else begin
                if (m_valid && bus.cmd_ready) begin
                    m_count = m_count + 16'd1;
                    m_valid = 0;
                end
                if (m_mode == 0 && exp_pop) begin
                    op = bus.r_data[82:80];
                    if (op == 3'b110) begin
                        m_err = 1; m_mode = 2;
                    end else if (op != 3'b111) begin
                        m_word = bus.r_data; m_valid = 1;
                    end
                end else if (m_mode == 1 && bus.empty) begin
                    m_mode = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic pop_now;
        @(negedge clk);
        check_cycle();
        pop_now = bus.r_enable;
        @(posedge clk);
        #1;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [82:0] w;
        n_cmp = 0; n_bad = 0;
        m_mode = 0; m_valid = 0; m_err = 0; m_count = 0; m_word = '0;
        rst = 1'b1;
        bus.cmd_ready = 1'b1;
        bus.flush = 1'b0;

        // Reset held with a word already waiting.
        w = {3'b101, 80'hAAAA_AAAA_AAAA_AAAA_AAAA};
        w[4:0] = 5'b10111;
        fifo.push_back(w);
        drive_fifo();
        ticks(2);
        chk("rst_r_enable", 64'(bus.r_enable), 64'd0);
        chk("rst_valid", 64'(bus.cmd_valid), 64'd0);
        chk("rst_count", 64'(bus.cmd_count), 64'd0);
        rst = 1'b0;

        // Single command.
        tick();
        chk("single_valid", 64'(bus.cmd_valid), 64'd1);
        chk("single_opcode", 64'(bus.cmd_opcode), 64'h5);
        chk("single_x0", 64'(bus.cmd_x0), 64'h2AA);
        chk("single_y0", 64'(bus.cmd_y0), 64'h155);
        chk("single_color", 64'(bus.cmd_color), 64'hAAAAAA);
        tick();
        chk("single_count", 64'(bus.cmd_count), 64'd1);

        // Backpressure: one pop then hold, then drain at one per cycle.
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            fifo.push_back(mk(3'b001, 10'(i * 100 + 7), 9'(i * 50 + 3), 10'(1000 - i),
                              9'(511 - i), 24'(24'h123456 + i)));
        drive_fifo();
        ticks(4);
        chk("bp_remaining", 64'(fifo.size()), 64'd3);
        chk("bp_held_x0", 64'(bus.cmd_x0), 64'd7);
        bus.cmd_ready = 1'b1;
        ticks(4);
        chk("bp_count", 64'(bus.cmd_count), 64'd5);   // 1 earlier + 4 here
        chk("bp_valid", 64'(bus.cmd_valid), 64'd0);

        // NOP word is consumed silently.
        fifo.push_back({83{1'b1}});
        drive_fifo();
        ticks(2);
        chk("nop_fifo", 64'(fifo.size()), 64'd0);
        chk("nop_valid", 64'(bus.cmd_valid), 64'd0);
        chk("nop_count", 64'(bus.cmd_count), 64'd5);

        // Illegal opcode traps; three good words stay behind it.
        fifo.push_back(mk(3'b110, 10'd1, 9'd2, 10'd3, 9'd4, 24'd5));
        for (int i = 0; i < 3; i++)
            fifo.push_back(mk(3'b001, 10'(i), 9'(i), 10'(i), 9'(i), 24'(i)));
        drive_fifo();
        tick();
        chk("trap_err", 64'(bus.err), 64'd1);
        ticks(3);
        chk("trap_r_enable", 64'(bus.r_enable), 64'd0);
        chk("trap_remaining", 64'(fifo.size()), 64'd3);

        // One-cycle flush drains the FIFO, then back to normal issue.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_err", 64'(bus.err), 64'd0);
        ticks(4);
        chk("flush_drained", 64'(fifo.size()), 64'd0);
        chk("flush_valid", 64'(bus.cmd_valid), 64'd0);
        fifo.push_back(mk(3'b001, 10'h3FF, 9'h1FF, 10'h200, 9'h100, 24'hFEDCBA));
        drive_fifo();
        tick();
        chk("post_flush_valid", 64'(bus.cmd_valid), 64'd1);
        chk("post_flush_opcode", 64'(bus.cmd_opcode), 64'h1);
        chk("post_flush_x0", 64'(bus.cmd_x0), 64'h3FF);
        tick();
        chk("post_flush_count", 64'(bus.cmd_count), 64'd6);

        // Reset while a command is pending and words remain.
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            fifo.push_back(mk(3'(i), 10'(i + 20), 9'(i + 30), 10'(i + 40), 9'(i + 50),
                              24'(i + 60)));
        drive_fifo();
        tick();
        chk("pre_rst_valid", 64'(bus.cmd_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
        chk("mid_rst_count", 64'(bus.cmd_count), 64'd0);
        chk("mid_rst_r_enable", 64'(bus.r_enable), 64'd0);
        chk("mid_rst_fifo", 64'(fifo.size()), 64'd2);
        tick();
        rst = 1'b0;
        bus.cmd_ready = 1'b1;
        ticks(3);
        chk("post_rst_count", 64'(bus.cmd_count), 64'd2);
        chk("post_rst_fifo", 64'(fifo.size()), 64'd0);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
